// File: rtl/register_file_writer.sv
// register_file_writer
// Write-side controller for a 2**ADDRESS_REGISTERS x DATA_WIDTH register file.
// Drives the file's write port either from a zero-fill sweep over every
// address (clear) or from a valid/ready stream written to consecutive,
// wrapping addresses starting at a base (burst load).
//
// Ports:
//   clk, rst           - clock (rising edge) and synchronous active-high reset
//   clear_start        - request a full zero sweep (wins over load_start)
//   load_start         - request a burst load; load_base/load_count sampled with it
//   load_base          - first address of the burst
//   load_count         - number of words, 0..DEPTH (larger values saturate)
//   in_valid/in_data   - upstream word stream
//   in_ready           - writer accepts a word this cycle (state decode only)
//   wr_en/wr_address/wr_data - register file write port (registered)
//   busy               - an operation is in progress (registered)
//   done               - one-cycle pulse at the end of an operation (registered)
module register_file_writer #(
  parameter int ADDRESS_REGISTERS = 4,
  parameter int DATA_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_start,
  input  logic                         load_start,
  input  logic [ADDRESS_REGISTERS-1:0] load_base,
  input  logic [ADDRESS_REGISTERS:0]   load_count,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         wr_en,
  output logic [ADDRESS_REGISTERS-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam logic [ADDRESS_REGISTERS:0]   DEPTH_CNT = {1'b1, {ADDRESS_REGISTERS{1'b0}}};
  localparam logic [ADDRESS_REGISTERS:0]   ONE_CNT   = {{ADDRESS_REGISTERS{1'b0}}, 1'b1};
  localparam logic [ADDRESS_REGISTERS-1:0] LAST_ADDR = {ADDRESS_REGISTERS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    LOAD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                       state_reg, state_next;
  logic [ADDRESS_REGISTERS-1:0] addr_reg, addr_next;    // next address to write
  logic [ADDRESS_REGISTERS:0]   count_reg, count_next;  // words still to accept
  logic                         wr_en_reg, wr_en_next;
  logic [ADDRESS_REGISTERS-1:0] wr_address_reg, wr_address_next;
  logic [DATA_WIDTH-1:0]        wr_data_reg, wr_data_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic [ADDRESS_REGISTERS:0]   eff_count;
  logic                         accept;

  // Counts beyond the array size would only overwrite words of the same burst.
  assign eff_count = (load_count > DEPTH_CNT) ? DEPTH_CNT : load_count;
  assign in_ready  = (state_reg == LOAD);
  assign accept    = in_valid && in_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      count_reg      <= '0;
      wr_en_reg      <= 1'b0;
      wr_address_reg <= '0;
      wr_data_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      count_reg      <= count_next;
      wr_en_reg      <= wr_en_next;
      wr_address_reg <= wr_address_next;
      wr_data_reg    <= wr_data_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (clear_start) begin
          state_next = CLEAR;
        end else if (load_start) begin
          // An empty burst still produces its done pulse, straight away.
          state_next = (load_count == '0) ? FINISH : LOAD;
        end
      end
      CLEAR: begin
        // Address 0 was issued on entry, so the sweep ends once the last
        // address is issued from here.
        if (addr_reg == LAST_ADDR) state_next = FINISH;
      end
      LOAD: begin
        if (accept && count_reg == ONE_CNT) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next values; everything is registered so the
  // final write and the done pulse land in the same cycle.
  always_comb begin
    addr_next       = addr_reg;
    count_next      = count_reg;
    wr_en_next      = 1'b0;
    wr_address_next = wr_address_reg;
    wr_data_next    = wr_data_reg;
    case (state_reg)
      IDLE: begin
        if (clear_start) begin
          wr_en_next      = 1'b1;
          wr_address_next = '0;
          wr_data_next    = '0;
          addr_next       = {{(ADDRESS_REGISTERS-1){1'b0}}, 1'b1};
        end else if (load_start) begin
          addr_next  = load_base;
          count_next = eff_count;
        end
      end
      CLEAR: begin
        wr_en_next      = 1'b1;
        wr_address_next = addr_reg;
        wr_data_next    = '0;
        addr_next       = addr_reg + 1'b1;
      end
      LOAD: begin
        if (accept) begin
          wr_en_next      = 1'b1;
          wr_address_next = addr_reg;
          wr_data_next    = in_data;
          addr_next       = addr_reg + 1'b1;  // wraps DEPTH-1 -> 0
          count_next      = count_reg - 1'b1;
        end
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == FINISH);
  end

  assign wr_en      = wr_en_reg;
  assign wr_address = wr_address_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
